axi_mem_bist128: RTL and testbench
==================================

Name: axi_mem_bist128

Overview:
- Upstream AXI4 128-bit master that drives the memory slave's s0 port in smart_run.
- Issues NUM_BURSTS write bursts of a deterministic address-derived pattern.
- Reads back each burst and compares every beat; mismatches are logged.
- Reports done/error/count to the testbench for self-checking memory/interconnect bring-up without the CPU.

Parameters:
- BASE_ADDR, 40'h0, byte address of first burst; 16B aligned (low 4 bits ignored).
- NUM_BURSTS, 16, write/read burst pairs per run (1..65535).
- BURST_LEN, 8'd3, AXI len field (beats-1) used for every burst.
- BIST_ID, 8'h05, value on awid/wid/arid.
- PATTERN, 32'hA5C3_5A3C, XOR seed for data generation.
- TIMEOUT, 1024, cycles allowed in any wait state before abort.

Ports:
- pll_core_cpuclk  input  1  clock.
- pad_cpu_rst_b  input  1  async active-low reset.
- bist_start  input  1  one-cycle start pulse; honoured only in IDLE or DONE.
- bist_done  output  1  high from run end until next start.
- bist_err  output  1  sticky; any mismatch, bad resp, rlast error or timeout.
- bist_timeout  output  1  sticky; run aborted by watchdog.
- err_cnt  output  16  saturating mismatching-beat count.
- err_addr  output  40  address of first mismatching beat.
- AW outputs: awaddr_s0 40, awid_s0 8, awlen_s0 8, awsize_s0 3, awburst_s0 2, awcache_s0 4, awprot_s0 3, awvalid_s0 1. AW input: awready_s0 1.
- W outputs: wdata_s0 128, wstrb_s0 16, wid_s0 8, wlast_s0 1, wvalid_s0 1. W input: wready_s0 1.
- B inputs: bid_s0 8, bresp_s0 2, bvalid_s0 1. B output: bready_s0 1.
- AR outputs: araddr_s0 40, arid_s0 8, arlen_s0 8, arsize_s0 3, arburst_s0 2, arcache_s0 4, arprot_s0 3, arvalid_s0 1. AR input: arready_s0 1.
- R inputs: rdata_s0 128, rid_s0 8, rresp_s0 2, rlast_s0 1, rvalid_s0 1. R output: rready_s0 1.

Behaviour:
- Reset: all valid/ready outputs 0, bist_done/bist_err/bist_timeout 0, err_cnt 0, err_addr 0, state IDLE, burst counter 0.
- Constants: size 3'b100, burst 2'b01 INCR, cache 4'b0011, prot 3'b000, wstrb 16'hFFFF.
- Burst k base: BASE_ADDR + k*(BURST_LEN+1)*16, 40-bit, wraps modulo 2^40. Beat address a = base + beat*16.
- Data: data(a) = {4{a[31:0] ^ PATTERN}}.
- FSM states: IDLE, AW, W, B, AR, R, NEXT, DONE.
- IDLE/DONE + bist_start -> AW. Clears err/timeout/err_cnt/err_addr/done and burst counter.
- AW: awvalid=1 until awready; -> W the cycle after handshake. arvalid is never high at the same time as awvalid.
- W: wvalid=1 continuously. Beat counter advances on wvalid&wready. wlast=1 when beat==BURST_LEN. Handshake on last beat -> B.
- B: bready=1. On bvalid: bresp!=0 or bid!=BIST_ID -> error flag only (not counted). Then -> AR.
- AR: arvalid=1 until arready; then -> R.
- R: rready=1. Each rvalid beat compares rdata to data(a). Mismatch: err_cnt+1 (saturate at 16'hFFFF); err_addr loads only on the first error of the run.
- R error flag only (not counted): rresp!=0, rid!=BIST_ID, or rlast != (beat==BURST_LEN).
- R exit: the beat with beat==BURST_LEN -> NEXT, regardless of rlast.
- NEXT: one cycle. If counter==NUM_BURSTS-1 -> DONE, else counter+1 -> AW.
- DONE: bist_done=1; all valids 0.
- Watchdog: counter resets on every state change and every handshake. Reaching TIMEOUT in AW/W/B/AR/R sets bist_timeout and bist_err, drops all valids/readies, -> DONE. Write and read aborts behave identically.
- bist_start outside IDLE/DONE is ignored.
- Async reset mid-burst returns to reset values immediately; no completion of the outstanding burst.
- Throughput: with a zero-wait slave, W sustains 1 beat/cycle.

Decomposition:
- Package axi_bist_pkg:
  - state enum.
  - AXI_SIZE_16B, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_DEF.
  - data-pattern function data(a).
- Sub-module axi_bist_chk: beat compare, err_cnt saturation, first-error capture, resp/id/rlast checks; driven by the FSM's beat strobe and expected address.

Test Plan:
- Fault-free model, NUM_BURSTS=4, BURST_LEN=3, BASE 40'h1000 -> 4 AW at 0x1000/0x1040/0x1080/0x10C0; 16 W beats with wlast on each 4th; bist_done=1, bist_err=0, err_cnt=0.
- Model corrupts rdata bit 0 at 0x1050 -> err_cnt=1, err_addr=40'h1050, bist_err=1, run still completes.
- Model stuck-at on 0x1000 and 0x1010, NUM_BURSTS=1 -> err_cnt=2, err_addr=40'h1000 (first only).
- bresp=2'b10 on burst 0 -> bist_err=1, err_cnt=0, done after 4 bursts.
- awready held low, TIMEOUT=1024 -> bist_timeout=1, bist_done=1 exactly 1024 cycles after awvalid rise; all valids low.
- Reset asserted mid-W beat 2 -> outputs at reset values next edge; new bist_start reruns cleanly from BASE.

Source files
------------

// File: rtl/axi_bist_pkg.sv
// Shared types, AXI encodings and the data-pattern generator for the 128-bit AXI memory BIST.
package axi_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_NEXT,
        ST_DONE
    } bist_state_e;

    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0]  AXI_CACHE_DEF  = 4'b0011;
    localparam logic [2:0]  AXI_PROT_DEF   = 3'b000;
    localparam logic [15:0] AXI_STRB_ALL   = 16'hFFFF;

    // Every 32-bit lane carries the same address-derived word.
    function automatic logic [127:0] bist_data(input logic [39:0] addr, input logic [31:0] seed);
        return {4{addr[31:0] ^ seed}};
    endfunction

endpackage

// File: rtl/axi_bist_chk.sv
// Read-beat and response checker: data compare, saturating error count, first-error address, protocol flags.
module axi_bist_chk
    import axi_bist_pkg::*;
#(
    parameter logic [7:0]  BIST_ID = 8'h05,
    parameter logic [31:0] PATTERN = 32'hA5C3_5A3C
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    input  logic         i_clr,
    input  logic         i_r_stb,
    input  logic [39:0]  i_exp_addr,
    input  logic         i_exp_last,
    input  logic [127:0] i_rdata,
    input  logic [7:0]   i_rid,
    input  logic [1:0]   i_rresp,
    input  logic         i_rlast,
    input  logic         i_b_stb,
    input  logic [7:0]   i_bid,
    input  logic [1:0]   i_bresp,
    output logic         o_err,
    output logic [15:0]  o_err_cnt,
    output logic [39:0]  o_err_addr
);

    logic        r_err;
    logic [15:0] r_err_cnt;
    logic [39:0] r_err_addr;
    logic        w_mismatch;
    logic        w_r_proto;
    logic        w_b_proto;

    assign w_mismatch = i_r_stb && (i_rdata != bist_data(i_exp_addr, PATTERN));
    assign w_r_proto  = i_r_stb && ((i_rresp != AXI_RESP_OKAY) || (i_rid != BIST_ID) ||
                                    (i_rlast != i_exp_last));
    assign w_b_proto  = i_b_stb && ((i_bresp != AXI_RESP_OKAY) || (i_bid != BIST_ID));

    // NOTE: non-blocking assignments so every register here reads pre-edge values of the others.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else if (i_clr) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else begin
            r_err <= r_err | w_mismatch | w_r_proto | w_b_proto;
            if (w_mismatch) begin
                if (r_err_cnt == 16'h0000)
                    r_err_addr <= i_exp_addr;
                if (r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_err      = r_err;
    assign o_err_cnt  = r_err_cnt;
    assign o_err_addr = r_err_addr;

endmodule

// File: rtl/axi_mem_bist128.sv
// AXI4 128-bit write-then-readback BIST master for the memory slave's s0 port.
module axi_mem_bist128
    import axi_bist_pkg::*;
#(
    parameter logic [39:0] BASE_ADDR  = 40'h0,
    parameter int          NUM_BURSTS = 16,
    parameter logic [7:0]  BURST_LEN  = 8'd3,
    parameter logic [7:0]  BIST_ID    = 8'h05,
    parameter logic [31:0] PATTERN    = 32'hA5C3_5A3C,
    parameter int          TIMEOUT    = 1024
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    input  logic         bist_start,
    output logic         bist_done,
    output logic         bist_err,
    output logic         bist_timeout,
    output logic [15:0]  err_cnt,
    output logic [39:0]  err_addr,
    output logic [39:0]  awaddr_s0,
    output logic [7:0]   awid_s0,
    output logic [7:0]   awlen_s0,
    output logic [2:0]   awsize_s0,
    output logic [1:0]   awburst_s0,
    output logic [3:0]   awcache_s0,
    output logic [2:0]   awprot_s0,
    output logic         awvalid_s0,
    input  logic         awready_s0,
    output logic [127:0] wdata_s0,
    output logic [15:0]  wstrb_s0,
    output logic [7:0]   wid_s0,
    output logic         wlast_s0,
    output logic         wvalid_s0,
    input  logic         wready_s0,
    input  logic [7:0]   bid_s0,
    input  logic [1:0]   bresp_s0,
    input  logic         bvalid_s0,
    output logic         bready_s0,
    output logic [39:0]  araddr_s0,
    output logic [7:0]   arid_s0,
    output logic [7:0]   arlen_s0,
    output logic [2:0]   arsize_s0,
    output logic [1:0]   arburst_s0,
    output logic [3:0]   arcache_s0,
    output logic [2:0]   arprot_s0,
    output logic         arvalid_s0,
    input  logic         arready_s0,
    input  logic [127:0] rdata_s0,
    input  logic [7:0]   rid_s0,
    input  logic [1:0]   rresp_s0,
    input  logic         rlast_s0,
    input  logic         rvalid_s0,
    output logic         rready_s0
);

    localparam logic [39:0]       BASE_ALIGNED = {BASE_ADDR[39:4], 4'h0};
    localparam logic [39:0]       BEAT_BYTES   = 40'd16;
    localparam logic [39:0]       BURST_BYTES  = 40'((int'(BURST_LEN) + 1) * 16);
    localparam logic [15:0]       LAST_BURST   = 16'(NUM_BURSTS - 1);
    localparam int                WDOG_W       = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT   = WDOG_W'(TIMEOUT - 1);

    bist_state_e       r_state;
    logic [15:0]       r_burst;
    logic [7:0]        r_beat;
    logic [WDOG_W-1:0] r_wdog;
    logic [39:0]       r_base;
    logic [39:0]       r_addr;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_wlast;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_done;
    logic              r_timeout;

    logic w_start;
    logic w_hs;
    logic w_wait;
    logic w_abort;
    logic w_r_stb;
    logic w_b_stb;
    logic w_last_beat;
    logic w_chk_err;

    assign w_start     = bist_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_r_stb     = r_rready && rvalid_s0;
    assign w_b_stb     = r_bready && bvalid_s0;
    assign w_hs        = (r_awvalid && awready_s0) || (r_wvalid && wready_s0) || w_b_stb ||
                         (r_arvalid && arready_s0) || w_r_stb;
    assign w_wait      = r_state inside {ST_AW, ST_W, ST_B, ST_AR, ST_R};
    assign w_abort     = w_wait && !w_hs && (r_wdog == WDOG_LIMIT);
    assign w_last_beat = (r_beat == BURST_LEN);

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_state   <= ST_IDLE;
            r_burst   <= '0;
            r_beat    <= '0;
            r_wdog    <= '0;
            r_base    <= BASE_ALIGNED;
            r_addr    <= BASE_ALIGNED;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_abort) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_wdog    <= '0;
            r_state   <= ST_DONE;
        end else begin
            // Watchdog only runs while stalled on the slave.
            r_wdog <= (w_wait && !w_hs) ? r_wdog + WDOG_W'(1) : '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bist_start) begin
                        r_state   <= ST_AW;
                        r_awvalid <= 1'b1;
                        r_burst   <= '0;
                        r_base    <= BASE_ALIGNED;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_AW: begin
                    if (r_awvalid && awready_s0) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (BURST_LEN == 8'd0);
                        r_beat    <= '0;
                        r_addr    <= r_base;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (r_wvalid && wready_s0) begin
                        if (w_last_beat) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= ST_B;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= r_addr + BEAT_BYTES;
                            r_wlast <= ((r_beat + 8'd1) == BURST_LEN);
                        end
                    end
                end
                ST_B: begin
                    if (w_b_stb) begin
                        r_bready  <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (r_arvalid && arready_s0) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_addr    <= r_base;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_stb) begin
                        if (w_last_beat) begin
                            r_rready <= 1'b0;
                            r_state  <= ST_NEXT;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= r_addr + BEAT_BYTES;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_burst == LAST_BURST) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_burst   <= r_burst + 16'd1;
                        r_base    <= r_base + BURST_BYTES;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_AW;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axi_bist_chk #(
        .BIST_ID (BIST_ID),
        .PATTERN (PATTERN)
    ) u_chk (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_clr           (w_start),
        .i_r_stb         (w_r_stb),
        .i_exp_addr      (r_addr),
        .i_exp_last      (w_last_beat),
        .i_rdata         (rdata_s0),
        .i_rid           (rid_s0),
        .i_rresp         (rresp_s0),
        .i_rlast         (rlast_s0),
        .i_b_stb         (w_b_stb),
        .i_bid           (bid_s0),
        .i_bresp         (bresp_s0),
        .o_err           (w_chk_err),
        .o_err_cnt       (err_cnt),
        .o_err_addr      (err_addr)
    );

    assign bist_done    = r_done;
    assign bist_err     = w_chk_err | r_timeout;
    assign bist_timeout = r_timeout;

    assign awaddr_s0  = r_base;
    assign awid_s0    = BIST_ID;
    assign awlen_s0   = BURST_LEN;
    assign awsize_s0  = AXI_SIZE_16B;
    assign awburst_s0 = AXI_BURST_INCR;
    assign awcache_s0 = AXI_CACHE_DEF;
    assign awprot_s0  = AXI_PROT_DEF;
    assign awvalid_s0 = r_awvalid;

    assign wdata_s0  = bist_data(r_addr, PATTERN);
    assign wstrb_s0  = AXI_STRB_ALL;
    assign wid_s0    = BIST_ID;
    assign wlast_s0  = r_wlast;
    assign wvalid_s0 = r_wvalid;

    assign bready_s0 = r_bready;

    assign araddr_s0  = r_base;
    assign arid_s0    = BIST_ID;
    assign arlen_s0   = BURST_LEN;
    assign arsize_s0  = AXI_SIZE_16B;
    assign arburst_s0 = AXI_BURST_INCR;
    assign arcache_s0 = AXI_CACHE_DEF;
    assign arprot_s0  = AXI_PROT_DEF;
    assign arvalid_s0 = r_arvalid;

    assign rready_s0 = r_rready;

endmodule

// File: tb/tb_axi_mem_bist128.sv
// Scoreboard bench: behavioural AXI slave with fault injection, expected transfers queued per run.
module tb_axi_mem_bist128;

    logic pll_core_cpuclk = 1'b0;
    logic pad_cpu_rst_b   = 1'b0;
    logic bist_start      = 1'b0;
    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    logic         bist_done, bist_err, bist_timeout;
    logic [15:0]  err_cnt;
    logic [39:0]  err_addr;
    logic [39:0]  awaddr_s0, araddr_s0;
    logic [7:0]   awid_s0, awlen_s0, wid_s0, arid_s0, arlen_s0;
    logic [2:0]   awsize_s0, awprot_s0, arsize_s0, arprot_s0;
    logic [1:0]   awburst_s0, arburst_s0;
    logic [3:0]   awcache_s0, arcache_s0;
    logic         awvalid_s0, awready_s0, wlast_s0, wvalid_s0, wready_s0;
    logic [127:0] wdata_s0, rdata_s0;
    logic [15:0]  wstrb_s0;
    logic [7:0]   bid_s0, rid_s0;
    logic [1:0]   bresp_s0, rresp_s0;
    logic         bvalid_s0, bready_s0, arvalid_s0, arready_s0;
    logic         rlast_s0, rvalid_s0, rready_s0;

    axi_mem_bist128 #(
        .BASE_ADDR  (40'h1000),
        .NUM_BURSTS (4),
        .BURST_LEN  (8'd3),
        .BIST_ID    (8'h05),
        .PATTERN    (32'hA5C3_5A3C),
        .TIMEOUT    (1024)
    ) dut (
        .pll_core_cpuclk (pll_core_cpuclk), .pad_cpu_rst_b (pad_cpu_rst_b),
        .bist_start (bist_start), .bist_done (bist_done), .bist_err (bist_err),
        .bist_timeout (bist_timeout), .err_cnt (err_cnt), .err_addr (err_addr),
        .awaddr_s0 (awaddr_s0), .awid_s0 (awid_s0), .awlen_s0 (awlen_s0), .awsize_s0 (awsize_s0),
        .awburst_s0 (awburst_s0), .awcache_s0 (awcache_s0), .awprot_s0 (awprot_s0),
        .awvalid_s0 (awvalid_s0), .awready_s0 (awready_s0),
        .wdata_s0 (wdata_s0), .wstrb_s0 (wstrb_s0), .wid_s0 (wid_s0), .wlast_s0 (wlast_s0),
        .wvalid_s0 (wvalid_s0), .wready_s0 (wready_s0),
        .bid_s0 (bid_s0), .bresp_s0 (bresp_s0), .bvalid_s0 (bvalid_s0), .bready_s0 (bready_s0),
        .araddr_s0 (araddr_s0), .arid_s0 (arid_s0), .arlen_s0 (arlen_s0), .arsize_s0 (arsize_s0),
        .arburst_s0 (arburst_s0), .arcache_s0 (arcache_s0), .arprot_s0 (arprot_s0),
        .arvalid_s0 (arvalid_s0), .arready_s0 (arready_s0),
        .rdata_s0 (rdata_s0), .rid_s0 (rid_s0), .rresp_s0 (rresp_s0), .rlast_s0 (rlast_s0),
        .rvalid_s0 (rvalid_s0), .rready_s0 (rready_s0)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } w_exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0]  q_aw[$];
    logic [39:0]  q_ar[$];
    w_exp_t       q_w[$];
    logic [65:0]  q_st[$];
    int           w_seen = 0;

    const logic [39:0] BURST_TBL [4] = '{40'h1000, 40'h1040, 40'h1080, 40'h10C0};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_extra(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT transfer with no expected entry queued", name);
    endtask

    function automatic logic [127:0] exp_data(input logic [39:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'hA5C3_5A3C;
        return {w, w, w, w};
    endfunction

    // ---------------- slave model ----------------
    bit           aw_en = 1'b1;
    int           bresp_err_burst = -1;
    int           b_count = 0;
    logic [127:0] mem      [logic [39:0]];
    logic [127:0] rd_xor   [logic [39:0]];
    logic [127:0] rd_stuck [logic [39:0]];

    function automatic logic [127:0] read_mem(input logic [39:0] a);
        logic [127:0] v;
        v = mem.exists(a) ? mem[a] : '0;
        if (rd_stuck.exists(a)) v = rd_stuck[a];
        if (rd_xor.exists(a))   v = v ^ rd_xor[a];
        return v;
    endfunction

    initial begin
        bit           f_aw, f_w, f_b, f_ar, f_r, b_pend, s_wlast;
        logic [39:0]  s_awaddr, s_araddr, wr_addr, rd_addr;
        logic [127:0] s_wdata;
        logic [7:0]   s_arlen;
        int           rd_cnt;
        {f_aw, f_w, f_b, f_ar, f_r, b_pend, s_wlast} = '0;
        s_awaddr = '0; s_araddr = '0; wr_addr = '0; rd_addr = '0; s_wdata = '0; s_arlen = '0;
        rd_cnt = 0;
        awready_s0 = 0; wready_s0 = 0; arready_s0 = 0;
        bvalid_s0 = 0; bid_s0 = 0; bresp_s0 = 0;
        rvalid_s0 = 0; rdata_s0 = '0; rid_s0 = 0; rresp_s0 = 0; rlast_s0 = 0;
        forever begin
            @(negedge pll_core_cpuclk);
            if (!pad_cpu_rst_b) begin
                {f_aw, f_w, f_b, f_ar, f_r, b_pend} = '0;
                rd_cnt = 0;
                awready_s0 = 0; wready_s0 = 0; arready_s0 = 0;
                bvalid_s0 = 0; rvalid_s0 = 0; rlast_s0 = 0;
                continue;
            end
            awready_s0 = aw_en; wready_s0 = 1; arready_s0 = 1;
            // Apply handshakes that completed on the posedge just passed.
            if (f_aw) wr_addr = s_awaddr;
            if (f_w) begin
                mem[wr_addr] = s_wdata;
                wr_addr += 40'd16;
                if (s_wlast) b_pend = 1;
            end
            if (f_b) bvalid_s0 = 0;
            if (f_ar) begin rd_addr = s_araddr; rd_cnt = int'(s_arlen) + 1; end
            if (f_r) begin rd_addr += 40'd16; rd_cnt--; end
            if (b_pend && !bvalid_s0) begin
                bvalid_s0 = 1; bid_s0 = 8'h05;
                bresp_s0 = (b_count == bresp_err_burst) ? 2'b10 : 2'b00;
                b_count++; b_pend = 0;
            end
            if (rd_cnt > 0) begin
                rvalid_s0 = 1; rdata_s0 = read_mem(rd_addr); rid_s0 = 8'h05;
                rresp_s0 = 2'b00; rlast_s0 = (rd_cnt == 1);
            end else begin
                rvalid_s0 = 0; rlast_s0 = 0;
            end
            f_aw = awvalid_s0 && awready_s0; s_awaddr = awaddr_s0;
            f_w  = wvalid_s0 && wready_s0;   s_wdata = wdata_s0; s_wlast = wlast_s0;
            f_b  = bvalid_s0 && bready_s0;
            f_ar = arvalid_s0 && arready_s0; s_araddr = araddr_s0; s_arlen = arlen_s0;
            f_r  = rvalid_s0 && rready_s0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge pll_core_cpuclk);
            #1;
            if (pad_cpu_rst_b) begin
                if (awvalid_s0 && awready_s0) begin
                    if (q_aw.size() == 0) report_extra("aw_extra");
                    else check("aw_beat", 256'({awaddr_s0, awid_s0, awlen_s0, awsize_s0, awburst_s0,
                                                awcache_s0, awprot_s0, arvalid_s0}),
                               256'({q_aw.pop_front(), 8'h05, 8'h03, 3'b100, 2'b01, 4'b0011, 3'b000, 1'b0}));
                end
                if (wvalid_s0 && wready_s0) begin
                    if (q_w.size() == 0) report_extra("w_extra");
                    else begin
                        w_exp_t e;
                        e = q_w.pop_front();
                        check("w_beat", 256'({wdata_s0, wlast_s0, wstrb_s0, wid_s0}),
                              256'({e.data, e.last, 16'hFFFF, 8'h05}));
                    end
                    w_seen++;
                end
                if (arvalid_s0 && arready_s0) begin
                    if (q_ar.size() == 0) report_extra("ar_extra");
                    else check("ar_beat", 256'({araddr_s0, arid_s0, arlen_s0, arsize_s0, arburst_s0,
                                                arcache_s0, arprot_s0, awvalid_s0}),
                               256'({q_ar.pop_front(), 8'h05, 8'h03, 3'b100, 2'b01, 4'b0011, 3'b000, 1'b0}));
                end
                if (bist_done && !done_q) begin
                    if (q_st.size() == 0) report_extra("status_extra");
                    else check("run_status", 256'({bist_done, bist_err, bist_timeout, err_cnt, err_addr,
                                                   awvalid_s0, wvalid_s0, arvalid_s0, bready_s0, rready_s0}),
                               256'({q_st.pop_front(), 5'b00000}));
                end
            end
            done_q = bist_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_bursts(input int n_aw, input int n_w, input int n_ar);
        for (int k = 0; k < n_aw; k++) q_aw.push_back(BURST_TBL[k]);
        for (int i = 0; i < n_w; i++) begin
            logic [39:0] a;
            a = BURST_TBL[i / 4] + 40'(16 * (i % 4));
            q_w.push_back('{data: exp_data(a), last: ((i % 4) == 3)});
        end
        for (int k = 0; k < n_ar; k++) q_ar.push_back(BURST_TBL[k]);
    endtask

    task automatic push_status(input logic err, input logic to, input logic [15:0] cnt,
                               input logic [39:0] addr);
        q_st.push_back({1'b1, err, to, cnt, addr});
    endtask

    task automatic pulse_start();
        @(negedge pll_core_cpuclk);
        bist_start = 1'b1;
        @(negedge pll_core_cpuclk);
        bist_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int i;
        i = 0;
        while (!bist_done && i < limit) begin
            @(negedge pll_core_cpuclk);
            i++;
        end
        if (!bist_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: bist_done not seen within %0d cycles", name, limit);
        end
        @(negedge pll_core_cpuclk);
        #2;
        check({name, "_queues_drained"}, 256'(q_aw.size() + q_w.size() + q_ar.size() + q_st.size()), 256'(0));
        q_aw.delete(); q_w.delete(); q_ar.delete(); q_st.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        #1;
        check("reset_state", 256'({awvalid_s0, wvalid_s0, wlast_s0, bready_s0, arvalid_s0, rready_s0,
                                   bist_done, bist_err, bist_timeout, err_cnt, err_addr}), 256'(0));
        repeat (3) @(posedge pll_core_cpuclk);
        #2 pad_cpu_rst_b = 1'b1;

        // 1: fault-free run
        b_count = 0; push_bursts(4, 16, 4); push_status(1'b0, 1'b0, 16'd0, 40'h0);
        pulse_start();
        wait_done("clean", 500);

        // 2: single-bit corruption on one read beat
        rd_xor[40'h1050] = 128'h1;
        b_count = 0; push_bursts(4, 16, 4); push_status(1'b1, 1'b0, 16'd1, 40'h1050);
        pulse_start();
        wait_done("bit_flip", 500);
        rd_xor.delete();

        // 3: two stuck beats, first-error capture only
        rd_stuck[40'h1000] = '0;
        rd_stuck[40'h1010] = '0;
        b_count = 0; push_bursts(4, 16, 4); push_status(1'b1, 1'b0, 16'd2, 40'h1000);
        pulse_start();
        wait_done("stuck", 500);
        rd_stuck.delete();

        // 4: SLVERR on first write response, plus a mid-run start that must be ignored
        bresp_err_burst = 0;
        b_count = 0; push_bursts(4, 16, 4); push_status(1'b1, 1'b0, 16'd0, 40'h0);
        pulse_start();
        repeat (5) @(negedge pll_core_cpuclk);
        pulse_start();
        wait_done("bresp_err", 500);
        bresp_err_burst = -1;

        // 5: awready stuck low -> watchdog abort
        aw_en = 1'b0;
        b_count = 0; push_status(1'b1, 1'b1, 16'd0, 40'h0);
        pulse_start();
        check("timeout_awvalid_rise", 256'(awvalid_s0), 256'(1));
        cyc = 0;
        while (!bist_done && cyc < 2000) begin
            @(negedge pll_core_cpuclk);
            cyc++;
        end
        check("timeout_cycles", 256'(cyc), 256'(1024));
        @(negedge pll_core_cpuclk);
        #2;
        check("timeout_queues_drained", 256'(q_aw.size() + q_w.size() + q_ar.size() + q_st.size()), 256'(0));
        q_st.delete();
        aw_en = 1'b1;

        // 6: async reset during the third write beat, then a clean rerun
        b_count = 0; push_bursts(1, 2, 0);
        w_seen = 0;
        pulse_start();
        cyc = 0;
        while (w_seen < 2 && cyc < 100) begin
            @(negedge pll_core_cpuclk);
            #2;
            cyc++;
        end
        check("reset_run_reached_beat2", 256'(w_seen), 256'(2));
        @(posedge pll_core_cpuclk);
        #2 pad_cpu_rst_b = 1'b0;
        #1;
        check("mid_burst_reset_state", 256'({awvalid_s0, wvalid_s0, wlast_s0, bready_s0, arvalid_s0, rready_s0,
                                             bist_done, bist_err, bist_timeout, err_cnt, err_addr}), 256'(0));
        check("mid_burst_reset_queues", 256'(q_aw.size() + q_w.size()), 256'(0));
        repeat (3) @(posedge pll_core_cpuclk);
        #2 pad_cpu_rst_b = 1'b1;
        b_count = 0; push_bursts(4, 16, 4); push_status(1'b0, 1'b0, 16'd0, 40'h0);
        pulse_start();
        wait_done("rerun_after_reset", 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
